// File: rtl/shift_sched_pkg.sv
// Shared types and helpers for the shift-unit scheduler.
// Optional feature macro: SHIFT_SCHED_FUNNEL_EN (enables the B-operand
// funnel ops FSR/FSL; when undefined those opcodes decode as illegal).
package shift_sched_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    OP_SRL         = 4'd0,
    OP_SRA         = 4'd1,
    OP_SLL         = 4'd2,
    OP_SRO         = 4'd3,
    OP_SLO         = 4'd4,
    OP_ROR         = 4'd5,
    OP_ROL         = 4'd6,
    OP_FSR         = 4'd7,
    OP_FSL         = 4'd8,
    OP_ILLEGAL_MIN = 4'd9
  } op_e;

  // Decoded core controls carried by the decode stage
  typedef struct packed {
    logic [XLEN-1:0] h;
    logic [XLEN-1:0] l;
    logic            rev;
    logic [4:0]      shamt;
    logic            id;
    logic            err;
  } s1_t;

  function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int unsigned i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  // Opcode -> core controls; illegal opcodes leave every core input at zero
  // so the core yields zero, and only err is raised.
  function automatic s1_t decode_op(
    input logic [3:0]      op,
    input logic [XLEN-1:0] a,
`ifdef SHIFT_SCHED_FUNNEL_EN
    input logic [XLEN-1:0] b,
`endif
    input logic [4:0]      shamt,
    input logic            id
  );
    s1_t d;
    d    = '0;
    d.id = id;
    case (op)
      OP_SRL: d.l = a;
      OP_SRA: begin d.h = {XLEN{a[XLEN-1]}}; d.l = a; end
      OP_SLL: begin d.l = a; d.rev = 1'b1; end
      OP_SRO: begin d.h = '1; d.l = a; end
      OP_SLO: begin d.h = '1; d.l = a; d.rev = 1'b1; end
      OP_ROR: begin d.h = a;  d.l = a; end
      OP_ROL: begin d.h = a;  d.l = a; d.rev = 1'b1; end
`ifdef SHIFT_SCHED_FUNNEL_EN
      OP_FSR: begin d.h = b;  d.l = a; end
      OP_FSL: begin d.h = b;  d.l = a; d.rev = 1'b1; end
`endif
      default: d.err = 1'b1;
    endcase
    if (!d.err) d.shamt = shamt;
    return d;
  endfunction

endpackage

// File: rtl/shift_unit_sched_core.sv
// Combinational funnel shifter: Y = low word of {H,L} >> shamt, with an
// optional bit-reversal wrapper that turns right shifts into left shifts.
module funnel_shift_core
  import shift_sched_pkg::*;
(
  input  logic [XLEN-1:0] i_h,
  input  logic [XLEN-1:0] i_l,
  input  logic [4:0]      i_shamt,
  input  logic            i_rev,
  output logic [XLEN-1:0] o_y
);

  logic [2*XLEN-1:0] w_cat;
  logic [XLEN-1:0]   w_sh;

  // Reverse inputs, shift right, reverse back when a left shift is wanted
  always_comb begin
    w_cat = i_rev ? {bitrev(i_h), bitrev(i_l)} : {i_h, i_l};
    w_sh  = XLEN'(w_cat >> i_shamt);
    o_y   = i_rev ? bitrev(w_sh) : w_sh;
  end

endmodule

// File: rtl/shift_unit_sched.sv
// Two-requester round-robin scheduler in front of one funnel-shift core,
// with a decode stage (registered or transparent) and a result register.
// Optional feature macro: SHIFT_SCHED_FUNNEL_EN (FSR/FSL ops and B operands).
module shift_unit_sched #(
  parameter int REG_DECODE = 1,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [3:0]      r0_op,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  input  logic [4:0]      r0_shamt,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [3:0]      r1_op,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  input  logic [4:0]      r1_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_y,
  output logic            out_id,
  output logic            out_err
);

  import shift_sched_pkg::*;

  if (XLEN != 32) begin : g_xlen_chk
    $error("shift_unit_sched: only XLEN=32 is supported");
  end

  logic            r_rr;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_y;
  logic            r_out_id;
  logic            r_out_err;

  logic            w_s2_en;
  logic            w_s1_en;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_gnt_any;
  logic [3:0]      w_op;
  logic [XLEN-1:0] w_a;
  logic [4:0]      w_shamt;
  s1_t             w_dec;
  s1_t             w_s1;
  logic            w_s1_valid;
  logic [XLEN-1:0] w_core_y;

  assign w_s2_en = !r_out_valid || out_ready;

  // Round-robin grant, only when the decode stage can take a new entry
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_s1_en) begin
      if (r0_valid && r1_valid) begin
        w_gnt0 = r_rr;
        w_gnt1 = !r_rr;
      end else begin
        w_gnt0 = r0_valid;
        w_gnt1 = r1_valid;
      end
    end
  end

  assign w_gnt_any = w_gnt0 || w_gnt1;
  assign r0_ready  = w_gnt0;
  assign r1_ready  = w_gnt1;

  assign w_op    = w_gnt1 ? r1_op    : r0_op;
  assign w_a     = w_gnt1 ? r1_a     : r0_a;
  assign w_shamt = w_gnt1 ? r1_shamt : r0_shamt;

`ifdef SHIFT_SCHED_FUNNEL_EN
  logic [XLEN-1:0] w_b;
  assign w_b   = w_gnt1 ? r1_b : r0_b;
  assign w_dec = decode_op(w_op, w_a, w_b, w_shamt, w_gnt1);
`else
  logic w_unused_b;
  assign w_unused_b = ^{r0_b, r1_b};
  assign w_dec      = decode_op(w_op, w_a, w_shamt, w_gnt1);
`endif

  // Pointer remembers the last granted requester; reset favours r0 first
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        r_rr <= 1'b1;
    else if (w_gnt_any) r_rr <= w_gnt1;
  end

  if (REG_DECODE != 0) begin : g_s1_reg
    logic r_s1_valid;
    s1_t  r_s1;

    // A bubble here refills even while the result register is stalled
    assign w_s1_en = !r_s1_valid || w_s2_en;

    // Decode register: load a fresh grant or record the bubble
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_s1_valid <= 1'b0;
        r_s1       <= '0;
      end else if (w_s1_en) begin
        r_s1_valid <= w_gnt_any;
        if (w_gnt_any) r_s1 <= w_dec;
      end
    end

    assign w_s1_valid = r_s1_valid;
    assign w_s1       = r_s1;
  end else begin : g_s1_wire
    assign w_s1_en    = w_s2_en;
    assign w_s1_valid = w_gnt_any;
    assign w_s1       = w_dec;
  end

  funnel_shift_core u_core (
    .i_h     (w_s1.h),
    .i_l     (w_s1.l),
    .i_shamt (w_s1.shamt),
    .i_rev   (w_s1.rev),
    .o_y     (w_core_y)
  );

  // Result register: advances on drain or when empty, holds while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_id    <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= w_s1_valid;
      if (w_s1_valid) begin
        r_out_y   <= w_core_y;
        r_out_id  <= w_s1.id;
        r_out_err <= w_s1.err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_id    = r_out_id;
  assign out_err   = r_out_err;

endmodule
